// File: rtl/worm_navigator.sv
// rtl/worm_navigator.sv - target-driven move command initiator for the worm block
//
// Accepts a target grid position and issues move commands until the worm,
// tracked by a local shadow position, reaches it. One axis is resolved fully
// before the other; each axis ends with a one-cycle bubble, then done pulses.
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   tgt_valid/tgt_ready   target handshake; tgt_ns/tgt_ew 4-bit target
//   cmd/cmd_valid         move command {sub, axis, magnitude[1:0]}
//   cmd_ready             worm consumes cmd this cycle
//   done                  one-cycle pulse when the target is reached
//   pos_ns/pos_ew         5-bit shadow position
// Optional (macro NAV_CHECK_EN):
//   obs_ns/obs_ew         observed worm position, compared in the DONE cycle
//   sync_err              sticky mismatch flag; shadow resyncs to obs on mismatch

module worm_navigator #(
    parameter int MAX_STEP = 3,
    parameter int EW_FIRST = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tgt_valid,
    output logic       tgt_ready,
    input  logic [3:0] tgt_ns,
    input  logic [3:0] tgt_ew,
    output logic [3:0] cmd,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       done,
`ifdef NAV_CHECK_EN
    input  logic [4:0] obs_ns,
    input  logic [4:0] obs_ew,
    output logic       sync_err,
`endif
    output logic [4:0] pos_ns,
    output logic [4:0] pos_ew
);

    typedef enum logic [1:0] {IDLE, AX1, AX2, DONE} state_t;

    localparam logic       AX1_AXIS = (EW_FIRST != 0);
    localparam logic [5:0] MAX_MAG  = 6'(MAX_STEP);

    state_t      state, state_nxt;
    logic [3:0]  lat_ns, lat_ew;
    logic        axis;
    logic [5:0]  d;
    logic [5:0]  abs_d;
    logic [1:0]  mag;
    logic        on_axis;
    logic        moving;

    // Axis being resolved in the current AX state (0 = N/S, 1 = E/W).
    assign axis    = (state == AX2) ? ~AX1_AXIS : AX1_AXIS;
    assign on_axis = (state == AX1) || (state == AX2);

    // Signed 6-bit difference target - shadow on the active axis.
    always_comb begin
        if (axis) begin
            d = {2'b00, lat_ew} - {1'b0, pos_ew};
        end else begin
            d = {2'b00, lat_ns} - {1'b0, pos_ns};
        end
        abs_d = d[5] ? (~d + 6'd1) : d;
        mag   = (abs_d > MAX_MAG) ? MAX_MAG[1:0] : abs_d[1:0];
    end

    assign moving = on_axis && (d != 6'd0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (tgt_valid) state_nxt = AX1;
            AX1:  if (d == 6'd0) state_nxt = AX2;
            AX2:  if (d == 6'd0) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic. cmd depends only on state, latched target and shadow, so
    // it holds steady while cmd_ready is low (the shadow does not move).
    always_comb begin
        tgt_ready = (state == IDLE);
        done      = (state == DONE);
        cmd_valid = moving;
        cmd       = moving ? {d[5], axis, mag} : 4'b0000;
    end

    // Target latch and shadow position
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_ns <= 4'd0;
            lat_ew <= 4'd0;
            pos_ns <= 5'd0;
            pos_ew <= 5'd0;
        end else begin
            if (state == IDLE && tgt_valid) begin
                lat_ns <= tgt_ns;
                lat_ew <= tgt_ew;
            end
            if (moving && cmd_ready) begin
                if (axis) begin
                    pos_ew <= d[5] ? (pos_ew - {3'b000, mag}) : (pos_ew + {3'b000, mag});
                end else begin
                    pos_ns <= d[5] ? (pos_ns - {3'b000, mag}) : (pos_ns + {3'b000, mag});
                end
            end
`ifdef NAV_CHECK_EN
            if (state == DONE && ({obs_ns, obs_ew} != {pos_ns, pos_ew})) begin
                pos_ns <= obs_ns;
                pos_ew <= obs_ew;
            end
`endif
        end
    end

`ifdef NAV_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_err <= 1'b0;
        end else if (state == DONE && ({obs_ns, obs_ew} != {pos_ns, pos_ew})) begin
            sync_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_worm_navigator.sv
// tb/tb_worm_navigator.sv - self-checking bench for worm_navigator

module tb_worm_navigator;

    logic       clk = 1'b0;
    logic       rst;
    logic       tgt_valid;
    logic       tgt_ready;
    logic [3:0] tgt_ns, tgt_ew;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       done;
    logic [4:0] pos_ns, pos_ew;
`ifdef NAV_CHECK_EN
    logic [4:0] obs_ns, obs_ew;
    logic       sync_err;
    logic       force_obs;
    logic [4:0] forced_ew;
    assign obs_ns = pos_ns;
    assign obs_ew = force_obs ? forced_ew : pos_ew;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    worm_navigator #(.MAX_STEP(3), .EW_FIRST(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_ns    (tgt_ns),
        .tgt_ew    (tgt_ew),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .done      (done),
`ifdef NAV_CHECK_EN
        .obs_ns    (obs_ns),
        .obs_ew    (obs_ew),
        .sync_err  (sync_err),
`endif
        .pos_ns    (pos_ns),
        .pos_ew    (pos_ew)
    );

    typedef struct {
        logic [3:0]       tns;
        logic [3:0]       tew;
        int               ncmd;
        logic [7:0][3:0]  cmds;
        int               done_cyc;
        logic [4:0]       ens;
        logic [4:0]       eew;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present a target at the current negedge; returns at the negedge of cycle 1.
    task automatic send_target(input logic [3:0] ns, input logic [3:0] ew);
        check("tgt_ready_before_send", {31'd0, tgt_ready}, 32'd1);
        tgt_ns    = ns;
        tgt_ew    = ew;
        tgt_valid = 1'b1;
        @(negedge clk);
        tgt_valid = 1'b0;
    endtask

    // Sample each cycle from start_cyc until done; returns at the done negedge.
    task automatic collect(input int start_cyc, output int n,
                           output logic [7:0][3:0] c, output int done_cyc);
        n = 0;
        c = '0;
        done_cyc = -1;
        for (int cyc = start_cyc; cyc < start_cyc + 60; cyc++) begin
            if (done) begin
                done_cyc = cyc;
                check("done_cmd_valid", {31'd0, cmd_valid}, 32'd0);
                return;
            end
            check("busy_tgt_ready", {31'd0, tgt_ready}, 32'd0);
            if (cmd_valid) begin
                check("nonzero_mag", {31'd0, (cmd[1:0] != 2'b00)}, 32'd1);
                if (cmd_ready) begin
                    if (n < 8) c[n] = cmd;
                    n++;
                end
            end else begin
                check("bubble_cmd_zero", {28'd0, cmd}, 32'd0);
            end
            @(negedge clk);
        end
        check("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx, input int start_cyc);
        int n, dc;
        logic [7:0][3:0] c;
        collect(start_cyc, n, c, dc);
        check($sformatf("v%0d_ncmd", idx), n, v.ncmd);
        for (int i = 0; i < v.ncmd && i < 8; i++)
            check($sformatf("v%0d_cmd%0d", idx, i), {28'd0, c[i]}, {28'd0, v.cmds[i]});
        check($sformatf("v%0d_done_cyc", idx), dc, v.done_cyc);
        @(negedge clk);
        check($sformatf("v%0d_done_one_cycle", idx), {31'd0, done}, 32'd0);
        check($sformatf("v%0d_tgt_ready_after", idx), {31'd0, tgt_ready}, 32'd1);
        check($sformatf("v%0d_pos_ns", idx), {27'd0, pos_ns}, {27'd0, v.ens});
        check($sformatf("v%0d_pos_ew", idx), {27'd0, pos_ew}, {27'd0, v.eew});
    endtask

    initial begin
        vecs[0] = '{4'd7,  4'd0, 3, 32'h00000133, 6, 5'd7,  5'd0};
        vecs[1] = '{4'd2,  4'd9, 5, 32'h000777AB, 8, 5'd2,  5'd9};
        vecs[2] = '{4'd2,  4'd9, 0, 32'h00000000, 3, 5'd2,  5'd9};
        vecs[3] = '{4'd0,  4'd0, 4, 32'h0000FFFA, 7, 5'd0,  5'd0};
        vecs[4] = '{4'd15, 4'd1, 6, 32'h00533333, 9, 5'd15, 5'd1};

        rst       = 1'b1;
        tgt_valid = 1'b0;
        tgt_ns    = 4'd0;
        tgt_ew    = 4'd0;
        cmd_ready = 1'b1;
`ifdef NAV_CHECK_EN
        force_obs = 1'b0;
        forced_ew = 5'd0;
`endif
        @(negedge clk);
        @(negedge clk);
        check("rst_tgt_ready", {31'd0, tgt_ready}, 32'd1);
        check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        check("rst_cmd", {28'd0, cmd}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pos", {22'd0, pos_ns, pos_ew}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back targets: each is sent in the cycle tgt_ready returns.
        for (int i = 0; i < 5; i++) begin
            send_target(vecs[i].tns, vecs[i].tew);
            run_vec(vecs[i], i, 1);
        end

        // Backpressure: cmd_ready low for cycles 1..4 while moving to (10,0).
        begin
            int n, dc;
            logic [7:0][3:0] c;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            cmd_ready = 1'b0;
            send_target(4'd10, 4'd0);
            for (int i = 1; i <= 4; i++) begin
                check("bp_cmd", {28'd0, cmd}, 32'h3);
                check("bp_cmd_valid", {31'd0, cmd_valid}, 32'd1);
                check("bp_pos_ns", {27'd0, pos_ns}, 32'd0);
                @(negedge clk);
            end
            cmd_ready = 1'b1;
            collect(5, n, c, dc);
            check("bp_ncmd", n, 4);
            check("bp_cmds", {16'd0, c[3], c[2], c[1], c[0]}, 32'h1333);
            check("bp_done_cyc", dc, 11);
            @(negedge clk);
            check("bp_pos", {22'd0, pos_ns, pos_ew}, {22'd0, 5'd10, 5'd0});
        end

        // Busy target ignored, then reset mid-move toward (15,15).
        send_target(4'd15, 4'd15);
        tgt_ns    = 4'd3;
        tgt_ew    = 4'd3;
        tgt_valid = 1'b1;
        check("rr_c1", {27'd0, cmd_valid, cmd}, 32'h13);
        check("rr_busy_ready", {31'd0, tgt_ready}, 32'd0);
        @(negedge clk);
        check("rr_c2", {27'd0, cmd_valid, cmd}, 32'h12);
        @(negedge clk);
        tgt_valid = 1'b0;
        check("rr_c3_bubble", {27'd0, cmd_valid, cmd}, 32'h00);
        @(negedge clk);
        check("rr_c4", {27'd0, cmd_valid, cmd}, 32'h17);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rr_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        check("rr_cmd", {28'd0, cmd}, 32'd0);
        check("rr_tgt_ready", {31'd0, tgt_ready}, 32'd1);
        check("rr_pos", {22'd0, pos_ns, pos_ew}, 32'd0);
        @(negedge clk);
        check("rr_idle_hold", {30'd0, cmd_valid, done}, 32'd0);

`ifdef NAV_CHECK_EN
        check("chk_sync_err_init", {31'd0, sync_err}, 32'd0);
        forced_ew = 5'd3;
        force_obs = 1'b1;
        send_target(4'd0, 4'd0);
        @(negedge clk);
        @(negedge clk);
        check("chk_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        force_obs = 1'b0;
        check("chk_sync_err", {31'd0, sync_err}, 32'd1);
        check("chk_pos_ew", {27'd0, pos_ew}, 32'd3);
        @(negedge clk);
        @(negedge clk);
        check("chk_sync_err_sticky", {31'd0, sync_err}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/worm_navigator.md
Name: worm_navigator

Overview:
- Command initiator for the worm block. Accepts a target grid position (N/S, E/W), then issues a stream of 4-bit move commands on the worm's command bus until the worm reaches the target.
- Keeps a shadow copy of the worm position so it can plan each move without reading the worm back.
- Sits upstream of the worm; cmd drives the worm's 4-bit command input directly.

Parameters:
- MAX_STEP, 3, largest magnitude per command (legal 1..3).
- EW_FIRST, 0, 0 = resolve N/S axis first; 1 = resolve E/W axis first.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- tgt_valid  in  1  target request valid.
- tgt_ready  out  1  navigator can accept a target.
- tgt_ns  in  4  target N/S coordinate, 0..15.
- tgt_ew  in  4  target E/W coordinate, 0..15.
- cmd  out  4  worm command: [3] 0 = add (N/E), 1 = subtract (S/W); [2] axis, 0 = N/S, 1 = E/W; [1:0] magnitude.
- cmd_valid  out  1  cmd is a real move this cycle.
- cmd_ready  in  1  worm consumes cmd this cycle; tie high for the free-running worm.
- done  out  1  one-cycle pulse when the target is reached.
- pos_ns  out  5  shadow N/S position.
- pos_ew  out  5  shadow E/W position.

Behaviour:
- Reset values: state IDLE, tgt_ready=1, cmd_valid=0, cmd=4'b0000, done=0, pos_ns=pos_ew=0. These match the worm's power-up position.
- States are IDLE, AX1, AX2, DONE. AX1 is the first-resolved axis per EW_FIRST; AX2 is the other axis.
- IDLE:
  - tgt_ready=1.
  - On tgt_valid & tgt_ready, latch tgt_ns/tgt_ew and go to AX1 next cycle.
  - Otherwise stay in IDLE.
- AXk:
  - tgt_ready=0. d = latched target minus shadow position on axis k.
  - d != 0: cmd_valid=1; cmd[2]=axis; cmd[3]=(d<0); cmd[1:0]=min(|d|, MAX_STEP).
  - d != 0 and cmd_ready=1: shadow updates by ±magnitude at the clock edge.
  - d != 0 and cmd_ready=0: hold cmd stable. cmd and cmd_valid must not change until accepted.
  - d == 0: cmd_valid=0, cmd=4'b0000, advance (AX1→AX2, AX2→DONE). This is a one-cycle bubble per axis, including an axis that is already at target.
- DONE: done=1 for exactly one cycle, cmd_valid=0, then IDLE.
- Latency:
  - Target accepted at cycle 0 and cmd_ready held high: first cmd_valid in cycle 1.
  - Total cycles to done = 1 + ceil(|d_ns|/MAX_STEP) + ceil(|d_ew|/MAX_STEP) + 2 bubbles.
  - Target equal to the current position: done in cycle 3.
- Arithmetic:
  - Differences use signed 6-bit.
  - Shadow stays in 0..15 because targets are 4-bit and magnitude never exceeds |d|. No saturation path is exercised; the worm's saturation is never triggered by this block.
- Never issues a zero-magnitude command with cmd_valid=1.
- tgt_valid while busy: ignored. The new target is not latched and there is no error.
- Back-to-back targets: tgt_ready rises the cycle after done. A target presented in that cycle is accepted.
- rst mid-operation: next cycle is IDLE with all outputs at reset values, shadow=0, latched target discarded. The environment must reset the worm at the same time.

Optional Feature:
- Macro NAV_CHECK_EN.
- When defined:
  - Adds inputs obs_ns[4:0] and obs_ew[4:0], driven from worm out1/out2.
  - Adds output sync_err (1 bit).
  - In the DONE cycle, compare obs with the shadow. On mismatch, sync_err sets (sticky until rst) and the shadow loads obs.
- When undefined: no extra ports and no compare logic; behaviour otherwise identical.

Test Plan:
- Reset, then target (ns=7, ew=0), MAX_STEP=3, cmd_ready=1 -> cmds 0011, 0011, 0001; bubble; bubble; done pulse; pos_ns=7, pos_ew=0.
- From (7,0), target (2,9) -> cmds 1011, 1010 (S3, S2); bubble; 0111, 0111, 0111 (E3 ×3); bubble; done; pos=(2,9).
- Target equal to the current position (2,9) -> no cmd_valid; done in cycle 3 after acceptance; tgt_ready back high the next cycle.
- cmd_ready held low 4 cycles during the first move to (10,0) -> cmd=0011 stable, cmd_valid=1 throughout, shadow unchanged. After release the sequence completes: 0011, 0011, 0011, 0001.
- rst asserted mid-way through moving to (15,15) -> next cycle IDLE, cmd_valid=0, pos=(0,0). A tgt_valid asserted while busy before the rst is never latched.
- NAV_CHECK_EN: obs_ew forced to 3 while the shadow is 0 at DONE -> sync_err=1 and stays set; pos_ew=3 afterwards.
